// File: rtl/scene_pkg.sv
// Shared scene identifiers and transition rules for the scene controller and scene_mux.
package scene_pkg;

  localparam logic [1:0] MENU_ID      = 2'b00;
  localparam logic [1:0] BATTLE_ID    = 2'b01;
  localparam logic [1:0] ENDGAME_ID   = 2'b10;
  localparam logic [1:0] HOWTOPLAY_ID = 2'b11;

  localparam int ENDGAME_FRAMES_DEFAULT = 300;

  // Returns {valid, target}; the if/else order encodes battle_over > start > help > back.
  function automatic logic [2:0] scene_target(input logic [1:0] cur,
                                              input logic bo_ev, input logic start_ev,
                                              input logic help_ev, input logic back_ev);
    logic [2:0] t;
    t = 3'b000;
    case (cur)
      MENU_ID: begin
        if (start_ev)     t = {1'b1, BATTLE_ID};
        else if (help_ev) t = {1'b1, HOWTOPLAY_ID};
      end
      BATTLE_ID: begin
        if (bo_ev) t = {1'b1, ENDGAME_ID};
      end
      ENDGAME_ID: begin
        if (start_ev || back_ev) t = {1'b1, MENU_ID};
      end
      HOWTOPLAY_ID: begin
        if (back_ev) t = {1'b1, MENU_ID};
      end
      default: t = 3'b000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-bit registered rising-edge detector with synchronous reset.
module edge_rise (
  input  logic i_pclk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic d_q;

  always_ff @(posedge i_pclk) begin
    if (i_rst) d_q <= 1'b0;
    else       d_q <= i_d;
  end

  assign o_rise = i_d & ~d_q;

endmodule

// File: rtl/scene_ctl.sv
// Scene controller: queues one scene request and commits it on the next vsync rise
// so scene_mux never switches mid-frame; ENDGAME returns to MENU after a frame timeout.
module scene_ctl
  import scene_pkg::*;
#(
  parameter int ENDGAME_FRAMES = ENDGAME_FRAMES_DEFAULT,
  parameter int FRAME_CNT_W    = 9
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic       i_vs,
  input  logic       i_btn_start,
  input  logic       i_btn_help,
  input  logic       i_btn_back,
  input  logic       i_battle_over,
  output logic [1:0] o_sel,
  output logic       o_scene_start
);

  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(ENDGAME_FRAMES - 1);

  logic vs_ev, start_ev, help_ev, back_ev, bo_ev;

  edge_rise u_vs    (.i_pclk(i_pclk), .i_rst(i_rst), .i_d(i_vs),          .o_rise(vs_ev));
  edge_rise u_start (.i_pclk(i_pclk), .i_rst(i_rst), .i_d(i_btn_start),   .o_rise(start_ev));
  edge_rise u_help  (.i_pclk(i_pclk), .i_rst(i_rst), .i_d(i_btn_help),    .o_rise(help_ev));
  edge_rise u_back  (.i_pclk(i_pclk), .i_rst(i_rst), .i_d(i_btn_back),    .o_rise(back_ev));
  edge_rise u_bo    (.i_pclk(i_pclk), .i_rst(i_rst), .i_d(i_battle_over), .o_rise(bo_ev));

  logic                   pend_vld, pend_vld_n;
  logic [1:0]             pend_sel, pend_sel_n;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [1:0]             sel_n;
  logic                   start_n;
  logic [2:0]             req;

  always_comb begin
    pend_vld_n  = pend_vld;
    pend_sel_n  = pend_sel;
    frame_cnt_n = frame_cnt;
    sel_n       = o_sel;
    start_n     = 1'b0;
    req         = scene_target(o_sel, bo_ev, start_ev, help_ev, back_ev);

    // Any commit cycle drops same-cycle requests, since they were judged against the old scene.
    if (vs_ev && pend_vld) begin
      sel_n      = pend_sel;
      start_n    = 1'b1;
      pend_vld_n = 1'b0;
      if (pend_sel == ENDGAME_ID) frame_cnt_n = '0;
    end else if (vs_ev && o_sel == ENDGAME_ID && frame_cnt == LAST_FRAME) begin
      sel_n   = MENU_ID;
      start_n = 1'b1;
    end else begin
      if (vs_ev && o_sel == ENDGAME_ID) frame_cnt_n = frame_cnt + 1'b1;
      if (!pend_vld && req[2]) begin
        pend_vld_n = 1'b1;
        pend_sel_n = req[1:0];
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      o_sel         <= MENU_ID;
      o_scene_start <= 1'b0;
      pend_vld      <= 1'b0;
      pend_sel      <= MENU_ID;
      frame_cnt     <= '0;
    end else begin
      o_sel         <= sel_n;
      o_scene_start <= start_n;
      pend_vld      <= pend_vld_n;
      pend_sel      <= pend_sel_n;
      frame_cnt     <= frame_cnt_n;
    end
  end

endmodule

// File: tb/tb_scene_ctl.sv
// Bench for scene_ctl: directed vector table for the scene-flow corner cases, then
// random buttons and vsync checked against a frame-level scene model.
module tb_scene_ctl;

  localparam int FRAMES = 4;

  logic       clk = 1'b0;
  logic       rst, vs, st, hp, bk, bo;
  logic [1:0] o_sel;
  logic       o_scene_start;

  int vectors = 0;
  int miscompares = 0;

  scene_ctl #(.ENDGAME_FRAMES(FRAMES), .FRAME_CNT_W(9)) dut (
    .i_pclk(clk), .i_rst(rst), .i_vs(vs),
    .i_btn_start(st), .i_btn_help(hp), .i_btn_back(bk), .i_battle_over(bo),
    .o_sel(o_sel), .o_scene_start(o_scene_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vs, st, hp, bk, bo;
    logic [1:0] sel;
    logic       ss;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic s, input logic h,
                              input logic b, input logic o, input logic [1:0] e_sel,
                              input logic e_ss);
    vec_t x;
    x.rst = r; x.vs = v; x.st = s; x.hp = h; x.bk = b; x.bo = o;
    x.sel = e_sel; x.ss = e_ss;
    vecs.push_back(x);
  endfunction

  // Scene model: scenes 0..3, per-scene table of which button leads where.
  int tgt[4][4];
  int m_sel, m_pend_tgt, m_dwell;
  bit m_pend, m_ss;
  bit prev[5];

  task automatic modelEdge(input logic r, input logic v, input logic s, input logic h,
                           input logic b, input logic o);
    bit cur[5];
    bit ev[5];
    bit lost;
    cur[0] = o; cur[1] = s; cur[2] = h; cur[3] = b; cur[4] = v;
    m_ss = 0;
    if (r) begin
      m_sel = 0; m_pend = 0; m_pend_tgt = 0; m_dwell = 0;
      for (int i = 0; i < 5; i++) prev[i] = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      ev[i] = cur[i] && !prev[i];
      prev[i] = cur[i];
    end
    lost = 0;
    if (ev[4]) begin
      if (m_pend) begin
        m_sel = m_pend_tgt; m_pend = 0; m_ss = 1; lost = 1;
        if (m_sel == 2) m_dwell = 0;
      end else if (m_sel == 2) begin
        m_dwell++;
        if (m_dwell == FRAMES) begin
          m_sel = 0; m_ss = 1; lost = 1;
        end
      end
    end
    if (!lost && !m_pend) begin
      for (int k = 0; k < 4; k++) begin
        if (ev[k] && tgt[m_sel][k] >= 0) begin
          m_pend = 1; m_pend_tgt = tgt[m_sel][k];
          break;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic h,
                               input logic b, input logic o);
    rst = r; vs = v; st = s; hp = h; bk = b; bo = o;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [1:0] e_sel,
                             input logic e_ss);
    vectors++;
    if (o_sel !== e_sel || o_scene_start !== e_ss) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: got o_sel=%0d o_scene_start=%0d, expected o_sel=%0d o_scene_start=%0d",
               name, idx, o_sel, o_scene_start, e_sel, e_ss);
    end
  endtask

  initial begin
    rst = 1; vs = 0; st = 0; hp = 0; bk = 0; bo = 0;

    // rst vs st hp bk bo | sel ss
    add(1,0,0,0,0,0, 2'd0,0);
    // idle across three vs rises
    add(0,1,0,0,0,0, 2'd0,0); add(0,0,0,0,0,0, 2'd0,0);
    add(0,1,0,0,0,0, 2'd0,0); add(0,0,0,0,0,0, 2'd0,0);
    add(0,1,0,0,0,0, 2'd0,0); add(0,0,0,0,0,0, 2'd0,0);
    // start mid-frame, held through two frames
    add(0,0,1,0,0,0, 2'd0,0); add(0,0,1,0,0,0, 2'd0,0);
    add(0,1,1,0,0,0, 2'd1,1); add(0,1,1,0,0,0, 2'd1,0);
    add(0,0,1,0,0,0, 2'd1,0); add(0,1,1,0,0,0, 2'd1,0);
    add(0,0,0,0,0,0, 2'd1,0);
    // battle_over held, then ENDGAME timeout after 4 vs rises
    add(0,0,0,0,0,1, 2'd1,0); add(0,1,0,0,0,1, 2'd2,1);
    add(0,0,0,0,0,1, 2'd2,0); add(0,1,0,0,0,1, 2'd2,0);
    add(0,0,0,0,0,0, 2'd2,0); add(0,1,0,0,0,0, 2'd2,0);
    add(0,0,0,0,0,0, 2'd2,0); add(0,1,0,0,0,0, 2'd2,0);
    add(0,0,0,0,0,0, 2'd2,0); add(0,1,0,0,0,0, 2'd0,1);
    add(0,0,0,0,0,0, 2'd0,0);
    // back to ENDGAME, start at frame 2 returns at frame 3
    add(0,0,1,0,0,0, 2'd0,0); add(0,1,1,0,0,0, 2'd1,1);
    add(0,0,0,0,0,0, 2'd1,0); add(0,0,0,0,0,1, 2'd1,0);
    add(0,1,0,0,0,0, 2'd2,1); add(0,0,0,0,0,0, 2'd2,0);
    add(0,1,0,0,0,0, 2'd2,0); add(0,0,0,0,0,0, 2'd2,0);
    add(0,1,0,0,0,0, 2'd2,0); add(0,0,1,0,0,0, 2'd2,0);
    add(0,0,0,0,0,0, 2'd2,0); add(0,1,0,0,0,0, 2'd0,1);
    add(0,0,0,0,0,0, 2'd0,0);
    // start+help together: start wins, later help ignored
    add(0,0,1,1,0,0, 2'd0,0); add(0,0,0,0,0,0, 2'd0,0);
    add(0,0,0,1,0,0, 2'd0,0); add(0,1,0,1,0,0, 2'd1,1);
    add(0,0,0,0,0,0, 2'd1,0); add(0,1,0,0,0,0, 2'd1,0);
    add(0,0,0,0,0,0, 2'd1,0);
    // ENDGAME then back to MENU
    add(0,0,0,0,0,1, 2'd1,0); add(0,1,0,0,0,0, 2'd2,1);
    add(0,0,0,0,1,0, 2'd2,0); add(0,1,0,0,0,0, 2'd0,1);
    add(0,0,0,0,0,0, 2'd0,0);
    // back in MENU and help in HOWTOPLAY are ignored
    add(0,0,0,0,1,0, 2'd0,0); add(0,1,0,0,0,0, 2'd0,0);
    add(0,0,0,1,0,0, 2'd0,0); add(0,1,0,0,0,0, 2'd3,1);
    add(0,0,0,0,0,0, 2'd3,0); add(0,0,0,1,0,0, 2'd3,0);
    add(0,1,0,0,0,0, 2'd3,0); add(0,0,0,0,0,0, 2'd3,0);
    add(0,0,0,0,1,0, 2'd3,0); add(0,1,0,0,0,0, 2'd0,1);
    add(0,0,0,0,0,0, 2'd0,0);
    // help on the commit edge is lost
    add(0,0,1,0,0,0, 2'd0,0); add(0,1,0,1,0,0, 2'd1,1);
    add(0,0,0,0,0,0, 2'd1,0); add(0,1,0,0,0,0, 2'd1,0);
    add(0,0,0,0,0,0, 2'd1,0);
    // reset discards a pending ENDGAME request
    add(0,0,0,0,0,1, 2'd1,0); add(1,0,0,0,0,1, 2'd0,0);
    add(0,0,0,0,0,1, 2'd0,0); add(0,1,0,0,0,1, 2'd0,0);
    add(0,0,0,0,0,0, 2'd0,0);
    // start held through reset release is seen as an event
    add(1,0,1,0,0,0, 2'd0,0); add(0,0,1,0,0,0, 2'd0,0);
    add(0,1,1,0,0,0, 2'd1,1); add(0,0,0,0,0,0, 2'd1,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vs, vecs[i].st, vecs[i].hp, vecs[i].bk, vecs[i].bo);
      checkOutput("directed", i, vecs[i].sel, vecs[i].ss);
    end

    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) tgt[s][k] = -1;
    tgt[1][0] = 2;
    tgt[0][1] = 1;
    tgt[0][2] = 3;
    tgt[2][1] = 0;
    tgt[2][3] = 0;
    tgt[3][3] = 0;

    modelEdge(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rand_reset", 0, 2'(m_sel), m_ss);

    begin
      logic r, v, s, h, b, o;
      s = 0; h = 0; b = 0; o = 0;
      for (int c = 0; c < 4000; c++) begin
        r = ($urandom_range(0, 599) == 0);
        v = ((c % 16) < 3);
        if ($urandom_range(0, 9) == 0) s = ~s;
        if ($urandom_range(0, 9) == 0) h = ~h;
        if ($urandom_range(0, 9) == 0) b = ~b;
        if ($urandom_range(0, 7) == 0) o = ~o;
        modelEdge(r, v, s, h, b, o);
        applyStimulus(r, v, s, h, b, o);
        checkOutput("random", c, 2'(m_sel), m_ss);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scene_ctl.md
# scene_ctl

Game scene controller. It turns debounced player buttons and the battle-over flag into the 2-bit scene select that drives `scene_mux`, and emits a one-cycle scene-start pulse. All scene changes are committed only on a vertical-sync rising edge, so the mux never switches mid-frame. It sits directly upstream of `scene_mux` in the `i_pclk` domain.

## Interface
Parameters:
- ENDGAME_FRAMES, 300: number of frames ENDGAME is held before it automatically returns to MENU (5 s at 60 Hz). Legal range 1 to 2^FRAME_CNT_W.
- FRAME_CNT_W, 9: width of the ENDGAME frame counter.

Ports:
- i_pclk  in  1  pixel clock; all logic is on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_vs  in  1  vsync from the active timing chain. Frame boundary = rising edge.
- i_btn_start  in  1  debounced level, synchronous to i_pclk.
- i_btn_help  in  1  debounced level.
- i_btn_back  in  1  debounced level.
- i_battle_over  in  1  level or pulse from battle logic.
- o_sel  out  2  scene select: MENU=00, BATTLE=01, ENDGAME=10, HOWTOPLAY=11. Registered.
- o_scene_start  out  1  one-cycle pulse on the edge where o_sel is updated. Registered.

## Operation
- Edge detection: each button and i_vs is registered (x_q). An event is x & ~x_q. i_battle_over is also edge-detected, so a held level produces one event.
- Pending register: pend_vld (1 bit) and pend_sel (2 bits).
  - A valid event with pend_vld=0 loads the target scene and sets pend_vld.
  - While pend_vld=1, further events are ignored. The first request wins.
- Legal transitions (current o_sel: event -> target). Any other event is ignored.
  - MENU: start -> BATTLE; help -> HOWTOPLAY.
  - HOWTOPLAY: back -> MENU.
  - BATTLE: battle_over -> ENDGAME.
  - ENDGAME: start or back -> MENU.
- Same-cycle priority: battle_over > start > help > back.
- Commit: on a vs rising edge with pend_vld=1:
  - o_sel <= pend_sel
  - o_scene_start <= 1
  - pend_vld <= 0
  - An event arriving in that same cycle is not latched and is lost.
- ENDGAME timeout:
  - frame_cnt clears on commit into ENDGAME.
  - On each vs rising edge in ENDGAME with pend_vld=0: if frame_cnt == ENDGAME_FRAMES-1, commit MENU directly (o_sel=00, o_scene_start=1); otherwise increment frame_cnt.
  - A pending button request takes precedence over the timeout.
- Reset values: o_sel=00 (MENU), o_scene_start=0, pend_vld=0, pend_sel=00, frame_cnt=0. All x_q registers reset to 0.
- Reset mid-operation: discards any pending request. A button held high through reset release produces an event on the first cycle after reset.

## Timing
- Button event to pend_vld: 1 cycle (latched on the edge where the event is seen).
- Commit: o_sel and o_scene_start change on the i_pclk edge at which i_vs=1 and vs_q=0. scene_mux then presents the new scene one cycle later, because of its own output register.
- o_scene_start is high for exactly 1 cycle per commit and never fires without an o_sel update. Committing to the same value is impossible by construction.
- Worst-case request-to-commit latency is one frame plus 1 cycle.
- The ENDGAME dwell is exactly ENDGAME_FRAMES vs rising edges after the commit edge, with no button activity.

## Structure
- Shared package `scene_pkg` holds:
  - the scene ID localparams MENU_ID, BATTLE_ID, ENDGAME_ID, HOWTOPLAY_ID (00/01/10/11), also imported by scene_mux;
  - the default frame-count constant.
- One sub-module, `edge_rise`: a 1-bit register plus rise detect with synchronous reset, instantiated 5 times.
- Everything else is a single always block for registers plus a combinational next-state block.

## Test plan
- Reset then idle: o_sel=00 and o_scene_start=0 after reset, and stay so across 3 vs edges.
- Start pressed mid-frame in MENU: o_sel stays 00 until the next vs rise, then o_sel=01 with a 1-cycle o_scene_start. Holding start produces no second change.
- battle_over held high in BATTLE, ENDGAME_FRAMES=4: o_sel=10 at the next vs rise, then 00 on the 4th following vs rise with no buttons. Pressing start at frame 2 instead returns to 00 at frame 3.
- Start and help asserted in the same cycle in MENU: o_sel -> 01 (start priority). A help press after the latch is ignored and o_sel never reaches 11.
- Back pressed in MENU, help pressed in HOWTOPLAY: no pending request and no o_scene_start.
- Button event on the same cycle as vs rise: not latched and no change. i_rst asserted with pend_vld=1: the next vs rise leaves o_sel=00.
